// File: rtl/int_source_conditioner.sv
// rtl/int_source_conditioner.sv - per-line interrupt synchronizer, debouncer, masker and edge/level detector
//
// Conditions WIDTH raw interrupt lines into single-cycle request pulses for the
// interrupt manager's int_e vector.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   irq_in     in   WIDTH  raw asynchronous interrupt lines
//   s_reti     in   WIDTH  end-of-service vector; bit i re-arms level line i
//   cfg_we     in   1      configuration write strobe
//   cfg_addr   in   2      0 mask, 1 mode, 2 pending W1C, 3 reserved
//   cfg_wdata  in   WIDTH  write data
//   cfg_rdata  out  WIDTH  readback: 0 mask, 1 mode, 2 pending, 3 filtered state
//   int_e      out  WIDTH  registered one-cycle request pulses
//   pending    out  WIDTH  edge events latched while masked
module int_source_conditioner #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] irq_in,
    input  logic [WIDTH-1:0] s_reti,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] cfg_rdata,
    output logic [WIDTH-1:0] int_e,
    output logic [WIDTH-1:0] pending
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    logic [WIDTH-1:0]      sync1_q, sync2_q;
    logic [WIDTH-1:0]      filt_q, filt_d;
    logic [WIDTH-1:0]      filt_prev_q;
    logic [WIDTH-1:0][7:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      mode_q, mode_d;
    logic [WIDTH-1:0]      pend_q, pend_d;
    logic [WIDTH-1:0]      armed_q, armed_d;
    logic [WIDTH-1:0]      int_e_q, int_e_d;

    logic [WIDTH-1:0] rise, evt, gen_lvl, mode_chg, w1c;
    logic             wr_mask, wr_mode, wr_pend;

    // Debounce: filt follows sync2 only after DEBOUNCE consecutive disagreeing cycles.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == DB_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        wr_mask = cfg_we && (cfg_addr == 2'd0);
        wr_mode = cfg_we && (cfg_addr == 2'd1);
        wr_pend = cfg_we && (cfg_addr == 2'd2);

        // rise is asserted in the cycle after filt has just turned high.
        rise     = filt_q & ~filt_prev_q;
        evt      = (~mode_q & rise) | (mode_q & filt_q & armed_q);
        int_e_d  = mask_q & (evt | pend_q);
        gen_lvl  = mode_q & mask_q & filt_q & armed_q;

        mode_chg = wr_mode ? (cfg_wdata ^ mode_q) : '0;
        w1c      = wr_pend ? cfg_wdata : '0;

        mask_d   = wr_mask ? cfg_wdata : mask_q;
        mode_d   = wr_mode ? cfg_wdata : mode_q;

        // Emission and W1C clear; a fresh masked edge overrides the W1C.
        // A mode change on a bit discards any pending state for it.
        pend_d   = ((pend_q & ~mask_q & ~w1c) | (rise & ~mask_q & ~mode_q)) & ~mode_chg;

        // Generating a level pulse disarms the line even if s_reti arrives together.
        armed_d  = ((armed_q | s_reti) & ~gen_lvl) | mode_chg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            pend_q      <= '0;
            armed_q     <= '1;
            int_e_q     <= '0;
        end else begin
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            armed_q     <= armed_d;
            int_e_q     <= int_e_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0:    cfg_rdata = mask_q;
            2'd1:    cfg_rdata = mode_q;
            2'd2:    cfg_rdata = pend_q;
            default: cfg_rdata = filt_q;
        endcase
    end

    assign int_e   = int_e_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_int_source_conditioner.sv
// tb/tb_int_source_conditioner.sv - scoreboard testbench for int_source_conditioner
module tb_int_source_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic [7:0] s_reti;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [7:0] int_e;
    logic [7:0] pending;

    int_source_conditioner #(.WIDTH(8), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .s_reti    (s_reti),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .int_e     (int_e),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: every nonzero int_e sample must match the oldest expected pulse.
    always @(negedge clk) begin
        if (reset === 1'b0 && int_e !== 8'h00) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d got int_e=%h want none", cyc, int_e);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.at != cyc || e.val !== int_e) begin
                    fails++;
                    $display("FAIL pulse got int_e=%h at cyc %0d want %h at cyc %0d",
                             int_e, cyc, e.val, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input logic [7:0] val);
        exp_t e;
        e.at  = at;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check_rd(input string name, input logic [1:0] a, input logic [7:0] want);
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, want);
    endtask

    int k;

    initial begin
        reset     = 1'b1;
        irq_in    = '0;
        s_reti    = '0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = '0;
        tick(3);
        check("reset_int_e", int_e, 8'h00);
        check("reset_pending", pending, 8'h00);
        check_rd("reset_mask", 2'd0, 8'h00);
        check_rd("reset_mode", 2'd1, 8'h00);
        check_rd("reset_filt", 2'd3, 8'h00);
        reset = 1'b0;
        tick(1);

        // Basic edge latency on line 0.
        cfg_write(2'd0, 8'h01);
        k = cyc;
        irq_in[0] = 1'b1;
        expect_pulse(k + 7, 8'h01);
        tick(10);
        check_rd("filt_line0", 2'd3, 8'h01);
        irq_in[0] = 1'b0;
        tick(8);

        // Glitch rejection then minimum accepted pulse on line 2.
        cfg_write(2'd0, 8'hFF);
        irq_in[2] = 1'b1;
        tick(3);
        irq_in[2] = 1'b0;
        tick(8);
        check_rd("glitch_filt", 2'd3, 8'h00);
        k = cyc;
        irq_in[2] = 1'b1;
        expect_pulse(k + 7, 8'h04);
        tick(4);
        irq_in[2] = 1'b0;
        tick(12);

        // Masked edge goes pending, released by unmask.
        cfg_write(2'd0, 8'h00);
        irq_in[5] = 1'b1;
        tick(10);
        check("pend_set", pending, 8'h20);
        k = cyc;
        expect_pulse(k + 2, 8'h20);
        cfg_write(2'd0, 8'h20);
        tick(1);
        check("pend_released", pending, 8'h00);
        irq_in[5] = 1'b0;
        tick(8);

        // Pending cleared by W1C before unmasking: no pulse.
        cfg_write(2'd0, 8'h00);
        irq_in[5] = 1'b1;
        tick(10);
        check("pend_set2", pending, 8'h20);
        cfg_write(2'd2, 8'h20);
        check("pend_w1c", pending, 8'h00);
        cfg_write(2'd0, 8'h20);
        tick(5);
        irq_in[5] = 1'b0;
        tick(8);

        // Level mode on line 1 with re-arm.
        cfg_write(2'd0, 8'h02);
        cfg_write(2'd1, 8'h02);
        k = cyc;
        irq_in[1] = 1'b1;
        expect_pulse(k + 7, 8'h02);
        tick(12);
        k = cyc;
        s_reti = 8'h02;
        expect_pulse(k + 2, 8'h02);
        tick(1);
        s_reti = 8'h00;
        tick(5);
        // s_reti held through the generating cycle: disarm wins, no third re-fire.
        k = cyc;
        s_reti = 8'h02;
        expect_pulse(k + 2, 8'h02);
        tick(2);
        s_reti = 8'h00;
        tick(6);
        irq_in[1] = 1'b0;
        tick(8);
        cfg_write(2'd1, 8'h00);

        // Simultaneous rises on lines 0, 3, 7.
        cfg_write(2'd0, 8'hFF);
        k = cyc;
        irq_in = 8'h89;
        expect_pulse(k + 7, 8'h89);
        tick(10);
        irq_in = 8'h00;
        tick(8);

        // Reset during an in-progress debounce.
        irq_in[6] = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("rst_mid_int_e", int_e, 8'h00);
        check("rst_mid_pending", pending, 8'h00);
        check_rd("rst_mid_mask", 2'd0, 8'h00);
        check_rd("rst_mid_filt", 2'd3, 8'h00);
        irq_in[6] = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(12);
        check("rst_after_pending", pending, 8'h00);

        // Masked pending edge on line 4, switched to level mode, then unmasked.
        irq_in[4] = 1'b1;
        tick(10);
        check("l4_pend_set", pending, 8'h10);
        cfg_write(2'd1, 8'h10);
        check("l4_mode_clear", pending, 8'h00);
        tick(3);
        k = cyc;
        expect_pulse(k + 2, 8'h10);
        cfg_write(2'd0, 8'h10);
        tick(6);
        irq_in[4] = 1'b0;
        tick(8);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses got %0d outstanding want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
